// File: rtl/top_proj.sv
// Autonomous 4-phase unipolar stepper sequencer: prescaled step tick, N steps forward then N in reverse, forever.
// Optional build macro HALF_STEP_EN selects the 8-entry half-step sequence instead of the 4-entry full-step one.
module top_proj #(
    parameter int STEP_DIV      = 500000,
    parameter int STEPS_PER_DIR = 200
) (
    input  logic CLK100MHZ,
    input  logic RESET,
    output logic PMOD1_P7,
    output logic PMOD1_P8,
    output logic PMOD1_P9,
    output logic PMOD1_P10
);

    localparam int PRE_W = $clog2(STEP_DIV);
    localparam int CNT_W = $clog2(STEPS_PER_DIR + 1);
`ifdef HALF_STEP_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } state_t;

    logic             clk;
    logic             srst;
    state_t           state_reg, state_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] idx_step;
    logic [3:0]       coil_reg, coil_next;
    logic             tick;

    assign clk  = CLK100MHZ;
    assign srst = RESET;

    // Coil patterns ordered {A,B,C,D}; the sequence length is a power of two so index wrap is free.
    function automatic logic [3:0] pattern(input logic [IDX_W-1:0] idx);
`ifdef HALF_STEP_EN
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    pattern = 4'b1100;
            2'd1:    pattern = 4'b0110;
            2'd2:    pattern = 4'b0011;
            default: pattern = 4'b1001;
        endcase
`endif
    endfunction

    assign tick     = (pre_reg == PRE_W'(STEP_DIV - 1));
    assign idx_step = (state_reg == ST_REV) ? (idx_reg - 1'b1) : (idx_reg + 1'b1);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            pre_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            coil_reg  <= 4'b0000;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            coil_reg  <= coil_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pre_next   = tick ? '0 : pre_reg + 1'b1;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        coil_next  = coil_reg;
        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    // First tick only energises pattern 0; it is not counted as a step.
                    state_next = ST_FWD;
                    coil_next  = pattern('0);
                end
                ST_FWD, ST_REV: begin
                    idx_next  = idx_step;
                    coil_next = pattern(idx_step);
                    if (cnt_reg == CNT_W'(STEPS_PER_DIR - 1)) begin
                        cnt_next   = '0;
                        state_next = (state_reg == ST_FWD) ? ST_REV : ST_FWD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign {PMOD1_P7, PMOD1_P8, PMOD1_P9, PMOD1_P10} = coil_reg;

endmodule

// File: tb/tb_top_proj.sv
// Self-checking bench for top_proj (full-step build, STEP_DIV=4, STEPS_PER_DIR=6).
module tb_top_proj;

    localparam int DIV = 4;
    localparam int SPD = 6;

    typedef struct {
        int         gap;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p7, p8, p9, p10;
    logic [3:0] out;
    logic [3:0] prev;
    logic [3:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;
    int         tick_no = 0;

    assign out = {p7, p8, p9, p10};

    always #5 clk = ~clk;

    top_proj #(
        .STEP_DIV(DIV),
        .STEPS_PER_DIR(SPD)
    ) dut (
        .CLK100MHZ(clk),
        .RESET(rst),
        .PMOD1_P7(p7),
        .PMOD1_P8(p8),
        .PMOD1_P9(p9),
        .PMOD1_P10(p10)
    );

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected value enters the scoreboard when the tick period begins and is
    // retired on the tick edge; every intermediate edge must hold the old value.
    task automatic tick(input logic [3:0] want, input int gap);
        logic [3:0] exp_v;
        sb_q.push_back(want);
        for (int i = 1; i < gap; i++) begin
            step();
            check("hold", out, prev);
        end
        step();
        exp_v = sb_q.pop_front();
        check("tick", out, exp_v);
        $display("tick %0d: out=%b exp=%b", tick_no, out, exp_v);
        tick_no++;
        prev = exp_v;
    endtask

    initial begin
        logic [3:0] fs[4];
        logic [3:0] seq1[14];
        logic [3:0] seq2[8];
        logic [3:0] seq3[8];
        vec_t       vecs[14];
        int         m_idx;
        int         m_cnt;
        bit         m_fwd;
        logic [3:0] e;

        fs   = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        seq1 = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011,
                 4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100,
                 4'b0110};
        seq2 = '{4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011,
                 4'b0110, 4'b1100, 4'b1001};
        seq3 = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011,
                 4'b0110};
        for (int i = 0; i < 14; i++) vecs[i] = '{DIV, seq1[i]};

        // Reset held for three edges
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", out, 4'b0000);
        end
        rst  = 1'b0;
        prev = 4'b0000;

        // Start, forward run with 3->0 wrap, reverse run with 0->3 wrap, forward resumes
        for (int i = 0; i < 14; i++) tick(vecs[i].exp, vecs[i].gap);

        // Run into the next reverse phase until out=1001, then pulse reset
        for (int i = 0; i < 8; i++) tick(seq2[i], DIV);
        rst = 1'b1;
        step();
        check("midrev_reset", out, 4'b0000);
        rst  = 1'b0;
        prev = 4'b0000;

        // Restart behaves like power-up: forward, full six-step run, then reverse
        for (int i = 0; i < 8; i++) tick(seq3[i], DIV);

        // Long run against an independent model; state is reverse, index 1, one step done
        m_idx = 1;
        m_fwd = 1'b0;
        m_cnt = 1;
        for (int t = 0; t < 200; t++) begin
            m_idx = m_fwd ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
            m_cnt++;
            e = fs[m_idx];
            if (m_cnt == SPD) begin
                m_cnt = 0;
                m_fwd = !m_fwd;
            end
            tick(e, DIV);
            total++;
            if (!(out inside {4'b1100, 4'b0110, 4'b0011, 4'b1001})) begin
                bad++;
                $display("FAIL legal: got=%b want=one of 1100/0110/0011/1001", out);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
